// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - two-client request arbiter feeding a sync FIFO
//
// Purpose: accepts read/write requests from two clients, picks one per cycle
// (round-robin with an optional bounded lock), and writes the winning beat to
// a downstream FIFO one cycle after the grant, pulsing the winner's ACK.
//
// Ports:
//   iCLOCK, iRESET_SYNC       clock, synchronous active-high reset
//   iREMOVE                   synchronous flush of arbitration state / beat
//   iCk_REQ/RW/LOCK/ADDR/DATA client k request (k = 0, 1)
//   oCk_ACK                   one-cycle acceptance pulse to client k
//   oFIFO_WR_EN/oFIFO_WR_DATA FIFO write strobe and packed {id, rw, addr, data}
//   iFIFO_ALMOST_FULL         stops new grants
//   oGRANT_COUNT              running count of beats written (wraps)
module sdram_req_arbiter #(
  parameter int AW       = 24,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iREMOVE,
  input  logic                 iC0_REQ,
  input  logic                 iC1_REQ,
  input  logic                 iC0_RW,
  input  logic                 iC1_RW,
  input  logic                 iC0_LOCK,
  input  logic                 iC1_LOCK,
  input  logic [AW-1:0]        iC0_ADDR,
  input  logic [AW-1:0]        iC1_ADDR,
  input  logic [DW-1:0]        iC0_DATA,
  input  logic [DW-1:0]        iC1_DATA,
  output logic                 oC0_ACK,
  output logic                 oC1_ACK,
  output logic                 oFIFO_WR_EN,
  output logic [AW+DW+1:0]     oFIFO_WR_DATA,
  input  logic                 iFIFO_ALMOST_FULL,
  output logic [15:0]          oGRANT_COUNT
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
  // A lock of length 1 is exhausted by the grant that would enter it.
  localparam bit LOCK_EN = (LOCK_MAX > 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_ptr;
  logic [CW-1:0]       r_lock_cnt;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_wr_en;
  logic [AW+DW+1:0]    r_wr_data;
  logic [15:0]         r_count;

  logic                w_elig0;
  logic                w_elig1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_gnt;
  logic                w_sel_rw;
  logic                w_sel_lock;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_data;
  logic                w_own;
  logic                w_own_gnt;
  logic                w_own_lock;
  logic                w_own_req;
  logic                w_own_ack;
  logic [CW-1:0]       w_cnt_inc;

  // A client whose ACK is showing this cycle is still holding REQ for the
  // request just accepted, so it must not be granted again.
  assign w_elig0 = iC0_REQ & ~iFIFO_ALMOST_FULL & ~r_ack0;
  assign w_elig1 = iC1_REQ & ~iFIFO_ALMOST_FULL & ~r_ack1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!iRESET_SYNC && !iREMOVE) begin
      if (r_state == ST_LOCK0 && w_elig0) begin
        w_gnt0 = 1'b1;
      end else if (r_state == ST_LOCK1 && w_elig1) begin
        w_gnt1 = 1'b1;
      end else if (w_elig0 && w_elig1) begin
        if (r_ptr) w_gnt1 = 1'b1;
        else       w_gnt0 = 1'b1;
      end else if (w_elig0) begin
        w_gnt0 = 1'b1;
      end else if (w_elig1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_gnt      = w_gnt0 | w_gnt1;
  assign w_sel_rw   = w_gnt1 ? iC1_RW   : iC0_RW;
  assign w_sel_lock = w_gnt1 ? iC1_LOCK : iC0_LOCK;
  assign w_sel_addr = w_gnt1 ? iC1_ADDR : iC0_ADDR;
  assign w_sel_data = w_gnt1 ? iC1_DATA : iC0_DATA;

  // Signals of the client that currently owns the lock (only meaningful in LOCKk).
  assign w_own      = (r_state == ST_LOCK1);
  assign w_own_gnt  = w_own ? w_gnt1   : w_gnt0;
  assign w_own_lock = w_own ? iC1_LOCK : iC0_LOCK;
  assign w_own_req  = w_own ? iC1_REQ  : iC0_REQ;
  assign w_own_ack  = w_own ? r_ack1   : r_ack0;
  assign w_cnt_inc  = r_lock_cnt + CW'(1);

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_lock_cnt <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_count    <= '0;
    end else if (iREMOVE) begin
      // Flush drops the in-flight beat but keeps the beat count and last data.
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_lock_cnt <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_ack0  <= w_gnt0;
      r_ack1  <= w_gnt1;
      r_wr_en <= w_gnt;
      if (w_gnt) begin
        r_wr_data <= {w_gnt1, w_sel_rw, w_sel_addr, w_sel_data};
        r_count   <= r_count + 16'd1;
        r_ptr     <= w_gnt0;
      end

      case (r_state)
        ST_IDLE: begin
          if (LOCK_EN && w_gnt && w_sel_lock) begin
            r_state    <= w_gnt1 ? ST_LOCK1 : ST_LOCK0;
            r_lock_cnt <= CW'(1);
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (w_own_gnt) begin
            if (!w_own_lock || w_cnt_inc >= LOCK_MAX_C) begin
              r_state    <= ST_IDLE;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= w_cnt_inc;
            end
          end else if (!w_own_req && !w_own_ack) begin
            // Owner withdrew its request: release the lock.
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  assign oC0_ACK       = r_ack0;
  assign oC1_ACK       = r_ack1;
  assign oFIFO_WR_EN   = r_wr_en;
  assign oFIFO_WR_DATA = r_wr_data;
  assign oGRANT_COUNT  = r_count;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb/tb_sdram_req_arbiter.sv - directed self-checking bench for sdram_req_arbiter
module tb_sdram_req_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LOCK_MAX = 4;

  logic          clk;
  logic          rst;
  logic          remove;
  logic          c0_req, c1_req, c0_rw, c1_rw, c0_lock, c1_lock;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_data, c1_data;
  logic          c0_ack, c1_ack;
  logic          wr_en;
  logic [AW+DW+1:0] wr_data;
  logic          af;
  logic [15:0]   gcount;

  int checks = 0;
  int errors = 0;

  sdram_req_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .iCLOCK            (clk),
    .iRESET_SYNC       (rst),
    .iREMOVE           (remove),
    .iC0_REQ           (c0_req),
    .iC1_REQ           (c1_req),
    .iC0_RW            (c0_rw),
    .iC1_RW            (c1_rw),
    .iC0_LOCK          (c0_lock),
    .iC1_LOCK          (c1_lock),
    .iC0_ADDR          (c0_addr),
    .iC1_ADDR          (c1_addr),
    .iC0_DATA          (c0_data),
    .iC1_DATA          (c1_data),
    .oC0_ACK           (c0_ack),
    .oC1_ACK           (c1_ack),
    .oFIFO_WR_EN       (wr_en),
    .oFIFO_WR_DATA     (wr_data),
    .iFIFO_ALMOST_FULL (af),
    .oGRANT_COUNT      (gcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    remove = 0; af = 0;
    c0_req = 0; c1_req = 0; c0_rw = 0; c1_rw = 0; c0_lock = 0; c1_lock = 0;
    c0_addr = '0; c1_addr = '0; c0_data = '0; c1_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    c0_req = 1; c0_addr = 24'h00ABCD; c0_data = 16'h1234;
    rst = 1;
    step();
    step();
    checks++; if (c0_ack !== 1'b0) begin $display("FAIL reset_ack0 got %b want 0", c0_ack); errors++; end
    checks++; if (c1_ack !== 1'b0) begin $display("FAIL reset_ack1 got %b want 0", c1_ack); errors++; end
    checks++; if (wr_en !== 1'b0) begin $display("FAIL reset_wr_en got %b want 0", wr_en); errors++; end
    checks++; if (wr_data !== '0) begin $display("FAIL reset_wr_data got %h want 0", wr_data); errors++; end
    checks++; if (gcount !== 16'h0) begin $display("FAIL reset_count got %h want 0", gcount); errors++; end
    rst = 0;
    c0_req = 0;
    step();
  endtask

  task automatic test_single();
    logic [AW+DW+1:0] exp;
    do_reset();
    c0_req = 1; c0_rw = 1; c0_addr = 24'h000010; c0_data = 16'hBEEF;
    exp = {1'b0, 1'b1, 24'h000010, 16'hBEEF};
    step();
    checks++; if (c0_ack !== 1'b1) begin $display("FAIL single_ack0 got %b want 1", c0_ack); errors++; end
    checks++; if (c1_ack !== 1'b0) begin $display("FAIL single_ack1 got %b want 0", c1_ack); errors++; end
    checks++; if (wr_en !== 1'b1) begin $display("FAIL single_wr_en got %b want 1", wr_en); errors++; end
    checks++; if (wr_data !== exp) begin $display("FAIL single_wr_data got %h want %h", wr_data, exp); errors++; end
    checks++; if (gcount !== 16'd1) begin $display("FAIL single_count got %0d want 1", gcount); errors++; end
    c0_req = 0;
    step();
    checks++; if (wr_en !== 1'b0) begin $display("FAIL single_idle_wr_en got %b want 0", wr_en); errors++; end
  endtask

  task automatic test_fairness();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    c0_req = 1; c1_req = 1;
    c0_addr = 24'h000100; c1_addr = 24'h000200;
    for (int k = 0; k < 8; k++) begin
      step();
      if (c0_ack) n0++;
      if (c1_ack) n1++;
      checks++; if (c0_ack !== ((k % 2) == 0)) begin $display("FAIL fair_order k=%0d ack0 got %b want %b", k, c0_ack, (k % 2) == 0); errors++; end
      checks++; if (wr_en !== 1'b1) begin $display("FAIL fair_wr_en k=%0d got %b want 1", k, wr_en); errors++; end
      checks++; if ((c0_ack & c1_ack) !== 1'b0) begin $display("FAIL fair_both_ack k=%0d got 1 want 0", k); errors++; end
    end
    checks++; if (n0 != 4 || n1 != 4) begin $display("FAIL fair_counts got %0d/%0d want 4/4", n0, n1); errors++; end
    checks++; if (gcount !== 16'd8) begin $display("FAIL fair_gcount got %0d want 8", gcount); errors++; end
  endtask

  task automatic test_lock();
    // Expected ack pattern after the stall: C1 (lock beats pointer), C0, C1, C0, C1.
    logic exp1 [5];
    exp1[0] = 1; exp1[1] = 0; exp1[2] = 1; exp1[3] = 0; exp1[4] = 1;
    do_reset();
    c1_req = 1; c1_lock = 1;
    step();
    checks++; if (c1_ack !== 1'b1) begin $display("FAIL lock_first got ack1=%b want 1", c1_ack); errors++; end
    c0_req = 1; af = 1;
    step();
    step();
    checks++; if (wr_en !== 1'b0) begin $display("FAIL lock_stall_wr_en got %b want 0", wr_en); errors++; end
    af = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (c1_ack !== exp1[k] || c0_ack !== !exp1[k]) begin
        $display("FAIL lock_seq k=%0d got ack0=%b ack1=%b want ack1=%b", k, c0_ack, c1_ack, exp1[k]); errors++;
      end
    end
    // Fourth C1 grant exhausted the lock; after a stall the pointer picks C0.
    af = 1;
    step();
    step();
    af = 0;
    step();
    checks++; if (c0_ack !== 1'b1 || c1_ack !== 1'b0) begin $display("FAIL lock_release got ack0=%b ack1=%b want 1/0", c0_ack, c1_ack); errors++; end
  endtask

  task automatic test_backpressure();
    do_reset();
    c0_req = 1; c1_req = 1;
    step();
    checks++; if (c0_ack !== 1'b1) begin $display("FAIL bp_first got ack0=%b want 1", c0_ack); errors++; end
    af = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (wr_en !== 1'b0 || c0_ack !== 1'b0 || c1_ack !== 1'b0) begin
        $display("FAIL bp_hold k=%0d got wr_en=%b ack0=%b ack1=%b want 0", k, wr_en, c0_ack, c1_ack); errors++;
      end
    end
    af = 0;
    step();
    checks++; if (c1_ack !== 1'b1 || wr_en !== 1'b1) begin $display("FAIL bp_resume got ack1=%b wr_en=%b want 1/1", c1_ack, wr_en); errors++; end
    checks++; if (gcount !== 16'd2) begin $display("FAIL bp_count got %0d want 2", gcount); errors++; end
  endtask

  task automatic test_flush();
    logic [AW+DW+1:0] exp;
    do_reset();
    c0_req = 1; c0_rw = 1; c0_addr = 24'h123456; c0_data = 16'hA5A5;
    exp = {1'b0, 1'b1, 24'h123456, 16'hA5A5};
    remove = 1;
    step();
    checks++; if (wr_en !== 1'b0 || c0_ack !== 1'b0) begin $display("FAIL flush_drop got wr_en=%b ack0=%b want 0/0", wr_en, c0_ack); errors++; end
    remove = 0;
    step();
    checks++; if (c0_ack !== 1'b1 || wr_data !== exp) begin $display("FAIL flush_regrant got ack0=%b data=%h want 1/%h", c0_ack, wr_data, exp); errors++; end
    c0_req = 0;
    step();
    checks++; if (wr_en !== 1'b0 || gcount !== 16'd1) begin $display("FAIL flush_once got wr_en=%b count=%0d want 0/1", wr_en, gcount); errors++; end
    remove = 1;
    step();
    checks++; if (gcount !== 16'd1) begin $display("FAIL flush_count got %0d want 1", gcount); errors++; end
    remove = 0;
    c0_req = 1; c1_req = 1;
    step();
    checks++; if (c0_ack !== 1'b1 || c1_ack !== 1'b0) begin $display("FAIL flush_ptr got ack0=%b ack1=%b want 1/0", c0_ack, c1_ack); errors++; end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    c0_req = 1; c1_req = 1;
    for (int k = 0; k < 65535; k++) step();
    checks++; if (gcount !== 16'hFFFF) begin $display("FAIL wrap_preload got %h want ffff", gcount); errors++; end
    step();
    checks++; if (gcount !== 16'h0000) begin $display("FAIL wrap_zero got %h want 0000", gcount); errors++; end

    do_reset();
    c0_req = 1; c0_lock = 1; c0_rw = 1; c0_addr = 24'hFEDCBA; c0_data = 16'h5A5A;
    step();
    checks++; if (c0_ack !== 1'b1) begin $display("FAIL lock0_enter got ack0=%b want 1", c0_ack); errors++; end
    rst = 1;
    step();
    checks++; if (wr_en !== 1'b0 || c0_ack !== 1'b0 || c1_ack !== 1'b0) begin
      $display("FAIL midlock_reset got wr_en=%b ack0=%b ack1=%b want 0", wr_en, c0_ack, c1_ack); errors++;
    end
    checks++; if (wr_data !== '0 || gcount !== 16'h0) begin $display("FAIL midlock_reset_regs got data=%h count=%h want 0/0", wr_data, gcount); errors++; end
    rst = 0;
    clear_inputs();
    step();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_backpressure();
    test_flush();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
